video_src_gen: RTL and testbench

- Synthetic video stream transmitter: drives de/hsync/vsync, 8-bit RGB and pixel coordinates in the same stream format the centroid path consumes.
- Frame content is a white BOX_SIZE x BOX_SIZE square on black, so a frame source exists without HDMI input, for hardware bring-up and self-test of the centroid/mask pipeline.
- Sits in place of hdmi_in, upstream of the segmentation/centroid blocks.

---
 rtl/video_src_gen.sv | 191 +++++++++++++++++++
 tb/tb_video_src_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_src_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_src_gen
//  Description : Synthetic video source. Emits de/hsync/vsync, 8-bit RGB and
//                pixel coordinates for a white BOX_SIZE x BOX_SIZE square on
//                a black background. It stands in for the HDMI input stage so
//                the segmentation/centroid pipeline can run stand-alone.
//                Optional macro VSRC_BOUNCE_EN: the box bounces by one pixel
//                per frame in x and y instead of following pos_x/pos_y.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_src_gen #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int BOX_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [9:0] c_w,
    output logic [9:0] c_h,
    output logic       frame_start
);

    // Timing landmarks, all held at counter width so compares stay width-exact
    localparam logic [9:0]  c_HT_M1      = 10'(IMG_W + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_VT_M1      = 10'(IMG_H + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  c_IMG_W      = 10'(IMG_W);
    localparam logic [9:0]  c_HS_START   = 10'(IMG_W + H_FP);
    localparam logic [9:0]  c_HS_END     = 10'(IMG_W + H_FP + H_SYNC);
    localparam logic [9:0]  c_V_ACT_LAST = 10'(IMG_H - 1);
    localparam logic [9:0]  c_V_FP_LAST  = 10'(IMG_H + V_FP - 1);
    localparam logic [9:0]  c_V_SY_LAST  = 10'(IMG_H + V_FP + V_SYNC - 1);
    localparam logic [9:0]  c_MAX_X      = 10'(IMG_W - BOX_SIZE);
    localparam logic [9:0]  c_MAX_Y      = 10'(IMG_H - BOX_SIZE);
    // Box extent is added at 11 bits so bx+BOX_SIZE cannot wrap
    localparam logic [10:0] c_BOX        = 11'(BOX_SIZE);

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FRONT  = 2'd1,
        V_SYNCP  = 2'd2,
        V_BACK   = 2'd3
    } vstate_t;

    vstate_t    r_vstate;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [9:0] r_bx;
    logic [9:0] r_by;
    logic       r_de;
    logic       r_hsync;
    logic       r_vsync;
    logic [7:0] r_rgb;
    logic [9:0] r_c_w;
    logic [9:0] r_c_h;
    logic       r_frame_start;

    logic       w_hwrap;
    logic       w_frame_end;
    logic       w_active;
    logic       w_in_box;

    assign w_hwrap     = (r_hcnt == c_HT_M1);
    assign w_frame_end = w_hwrap && (r_vcnt == c_VT_M1);
    assign w_active    = (r_vstate == V_ACTIVE) && (r_hcnt < c_IMG_W);
    assign w_in_box    = (r_hcnt >= r_bx) && ({1'b0, r_hcnt} < ({1'b0, r_bx} + c_BOX)) &&
                         (r_vcnt >= r_by) && ({1'b0, r_vcnt} < ({1'b0, r_by} + c_BOX));

    // Horizontal and vertical raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= 10'd0;
            r_vcnt <= 10'd0;
        end else if (ce) begin
            if (w_hwrap) begin
                r_hcnt <= 10'd0;
                r_vcnt <= (r_vcnt == c_VT_M1) ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    // Vertical region FSM; advances at the end of the last line of each region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vstate <= V_ACTIVE;
        end else if (ce && w_hwrap) begin
            case (r_vstate)
                V_ACTIVE: if (r_vcnt == c_V_ACT_LAST) r_vstate <= V_FRONT;
                V_FRONT:  if (r_vcnt == c_V_FP_LAST)  r_vstate <= V_SYNCP;
                V_SYNCP:  if (r_vcnt == c_V_SY_LAST)  r_vstate <= V_BACK;
                V_BACK:   if (r_vcnt == c_VT_M1)      r_vstate <= V_ACTIVE;
                default:                              r_vstate <= V_ACTIVE;
            endcase
        end
    end

`ifdef VSRC_BOUNCE_EN
    logic r_dir_x;
    logic r_dir_y;

    // One bounce step: returns {new_dir, new_pos}; dir 0 means increasing
    function automatic logic [10:0] bounce_step(input logic [9:0] p,
                                                input logic       d,
                                                input logic [9:0] m);
        logic [10:0] res;
        if (m == 10'd0)
            res = {1'b0, 10'd0};
        else if (!d)
            res = (p >= m) ? {1'b1, p - 10'd1} : {1'b0, p + 10'd1};
        else
            res = (p == 10'd0) ? {1'b0, 10'd1} : {1'b1, p - 10'd1};
        return res;
    endfunction

    // Box moves one step per frame, reflecting off the image edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx    <= 10'd0;
            r_by    <= 10'd0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (ce && w_frame_end) begin
            {r_dir_x, r_bx} <= bounce_step(r_bx, r_dir_x, c_MAX_X);
            {r_dir_y, r_by} <= bounce_step(r_by, r_dir_y, c_MAX_Y);
        end
    end
`else
    // Box position follows the clamped inputs, sampled only between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx <= 10'd0;
            r_by <= 10'd0;
        end else if (ce && w_frame_end) begin
            r_bx <= (pos_x > c_MAX_X) ? c_MAX_X : pos_x;
            r_by <= (pos_y > c_MAX_Y) ? c_MAX_Y : pos_y;
        end
    end
`endif

    // Registered stream outputs describing the pixel at the current counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de          <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_rgb         <= 8'h00;
            r_c_w         <= 10'd0;
            r_c_h         <= 10'd0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_de          <= w_active;
            r_hsync       <= (r_hcnt >= c_HS_START) && (r_hcnt < c_HS_END);
            r_vsync       <= (r_vstate == V_SYNCP);
            r_rgb         <= (w_active && w_in_box) ? 8'hFF : 8'h00;
            r_frame_start <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
            if (w_active) begin
                r_c_w <= r_hcnt;
                r_c_h <= r_vcnt;
            end
        end
    end

    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_rgb;
    assign green       = r_rgb;
    assign blue        = r_rgb;
    assign c_w         = r_c_w;
    assign c_h         = r_c_h;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_src_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_src_gen
//  Description : Self-checking bench for video_src_gen. A raster model keyed
//                on a linear pixel index predicts every output each cycle;
//                hand-computed frame statistics pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_src_gen;

`ifdef VSRC_BOUNCE_EN
    localparam int P_W = 12, P_H = 12, P_HFP = 1, P_HS = 2, P_HBP = 1;
    localparam int P_VFP = 1, P_VS = 2, P_VBP = 1, P_BOX = 4;
`else
    localparam int P_W = 64, P_H = 64, P_HFP = 4, P_HS = 8, P_HBP = 4;
    localparam int P_VFP = 2, P_VS = 2, P_VBP = 2, P_BOX = 8;
`endif
    localparam int HT    = P_W + P_HFP + P_HS + P_HBP;
    localparam int VT    = P_H + P_VFP + P_VS + P_VBP;
    localparam int FRAME = HT * VT;
    localparam int MAXX  = P_W - P_BOX;
    localparam int MAXY  = P_H - P_BOX;

    logic       clk, rst_n, ce;
    logic [9:0] pos_x, pos_y;
    logic       de, hsync, vsync, frame_start;
    logic [7:0] red, green, blue;
    logic [9:0] c_w, c_h;

    video_src_gen #(
        .IMG_W(P_W), .IMG_H(P_H), .H_FP(P_HFP), .H_SYNC(P_HS), .H_BP(P_HBP),
        .V_FP(P_VFP), .V_SYNC(P_VS), .V_BP(P_VBP), .BOX_SIZE(P_BOX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pos_x(pos_x), .pos_y(pos_y),
        .de(de), .hsync(hsync), .vsync(vsync), .red(red), .green(green),
        .blue(blue), .c_w(c_w), .c_h(c_h), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit f_de(int t);
        return (t / HT) < P_H && (t % HT) < P_W;
    endfunction
    function automatic bit f_hs(int t);
        return (t % HT) >= P_W + P_HFP && (t % HT) < P_W + P_HFP + P_HS;
    endfunction
    function automatic bit f_vs(int t);
        return (t / HT) >= P_H + P_VFP && (t / HT) < P_H + P_VFP + P_VS;
    endfunction
    function automatic bit f_white(int t, int bx, int by);
        int px, ln;
        px = t % HT;
        ln = t / HT;
        return f_de(t) && px >= bx && px < bx + P_BOX && ln >= by && ln < by + P_BOX;
    endfunction
    function automatic int clamp(int v, int m);
        return (v > m) ? m : v;
    endfunction
    // Triangle wave: position of the bouncing box in frame k
    function automatic int bounce_pos(int k, int m);
        int r;
        if (m == 0) return 0;
        r = k % (2 * m);
        return (r <= m) ? r : 2 * m - r;
    endfunction

    int m_t, m_frame, m_bx, m_by;
    int e_de, e_hs, e_vs, e_rgb, e_cw, e_ch, e_fs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_frame <= 0; m_bx <= 0; m_by <= 0;
            e_de <= 0; e_hs <= 0; e_vs <= 0; e_rgb <= 0;
            e_cw <= 0; e_ch <= 0; e_fs <= 0;
        end else if (ce) begin
            e_de  <= int'(f_de(m_t));
            e_hs  <= int'(f_hs(m_t));
            e_vs  <= int'(f_vs(m_t));
            e_rgb <= f_white(m_t, m_bx, m_by) ? 255 : 0;
            e_fs  <= (m_t == 0) ? 1 : 0;
            if (f_de(m_t)) begin
                e_cw <= m_t % HT;
                e_ch <= m_t / HT;
            end
            if (m_t == FRAME - 1) begin
                m_t     <= 0;
                m_frame <= m_frame + 1;
`ifdef VSRC_BOUNCE_EN
                m_bx <= bounce_pos(m_frame + 1, MAXX);
                m_by <= bounce_pos(m_frame + 1, MAXY);
`else
                m_bx <= clamp(int'(pos_x), MAXX);
                m_by <= clamp(int'(pos_y), MAXY);
`endif
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("de", int'(de), e_de);
            chk("hsync", int'(hsync), e_hs);
            chk("vsync", int'(vsync), e_vs);
            chk("red", int'(red), e_rgb);
            chk("green", int'(green), e_rgb);
            chk("blue", int'(blue), e_rgb);
            chk("c_w", int'(c_w), e_cw);
            chk("c_h", int'(c_h), e_ch);
            chk("frame_start", int'(frame_start), e_fs);
        end
    end

    // ---------------- frame statistics ----------------
    typedef struct {
        int n_de, n_hs, n_vs, n_fs, n_white, n_overlap;
        int first_hs, first_vs, fs0, de0, cw0, ch0;
        int minx, maxx, miny, maxy, sumx, sumy;
    } stats_t;

    task automatic run_frame(input int chg_at, input int nx, input int ny,
                             output stats_t s);
        s = '{default: 0};
        s.first_hs = -1; s.first_vs = -1;
        s.minx = 9999; s.miny = 9999; s.maxx = -1; s.maxy = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == chg_at) begin
                pos_x = 10'(nx);
                pos_y = 10'(ny);
            end
            if (i == 0) begin
                s.fs0 = int'(frame_start); s.de0 = int'(de);
                s.cw0 = int'(c_w);         s.ch0 = int'(c_h);
            end
            if (de) s.n_de++;
            if (frame_start) s.n_fs++;
            if (hsync) begin s.n_hs++; if (s.first_hs < 0) s.first_hs = i; end
            if (vsync) begin s.n_vs++; if (s.first_vs < 0) s.first_vs = i; end
            if (de && (hsync || vsync)) s.n_overlap++;
            if (red == 8'hFF) begin
                s.n_white++;
                s.sumx += int'(c_w); s.sumy += int'(c_h);
                if (int'(c_w) < s.minx) s.minx = int'(c_w);
                if (int'(c_w) > s.maxx) s.maxx = int'(c_w);
                if (int'(c_h) < s.miny) s.miny = int'(c_h);
                if (int'(c_h) > s.maxy) s.maxy = int'(c_h);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    stats_t st;
    bit     found;

    initial begin
        rst_n = 1'b1; ce = 1'b0; pos_x = 10'd10; pos_y = 10'd20;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_de", int'(de), 0);
        chk("reset_fs", int'(frame_start), 0);
        #1 rst_n = 1'b1; ce = 1'b1;

`ifdef VSRC_BOUNCE_EN
        for (int f = 0; f < 20; f++) begin
            run_frame(FRAME / 2, $urandom_range(1023), $urandom_range(1023), st);
            chk("bounce_white_count", st.n_white, P_BOX * P_BOX);
            if (f == 0)  begin chk("bounce_x_f0", st.minx, 0); chk("bounce_fs0", st.fs0, 1); end
            if (f == 8)  begin chk("bounce_x_f8", st.minx, 8); chk("bounce_y_f8", st.miny, 8); end
            if (f == 9)  begin chk("bounce_x_f9", st.minx, 7); chk("bounce_y_f9", st.miny, 7); end
            if (f == 17) chk("bounce_x_f17", st.minx, 1);
        end
`else
        // Frame 0: box at reset position (0,0); full timing pins
        run_frame(-1, 0, 0, st);
        chk("f0_fs_first", st.fs0, 1);
        chk("f0_de_first", st.de0, 1);
        chk("f0_cw_first", st.cw0, 0);
        chk("f0_ch_first", st.ch0, 0);
        chk("f0_de_count", st.n_de, 4096);
        chk("f0_fs_count", st.n_fs, 1);
        chk("f0_hs_count", st.n_hs, 560);
        chk("f0_hs_first", st.first_hs, 68);
        chk("f0_vs_count", st.n_vs, 160);
        chk("f0_vs_first", st.first_vs, 5280);
        chk("f0_de_sync_overlap", st.n_overlap, 0);
        chk("f0_white_minx", st.minx, 0);
        // Frame 1: pos (10,20) sampled at boundary; request clamp mid-frame
        run_frame(2000, 100, 60, st);
        chk("f1_white_count", st.n_white, 64);
        chk("f1_minx", st.minx, 10);
        chk("f1_maxx", st.maxx, 17);
        chk("f1_miny", st.miny, 20);
        chk("f1_maxy", st.maxy, 27);
        chk("f1_centroid_x", st.sumx / st.n_white, 13);
        chk("f1_centroid_y", st.sumy / st.n_white, 23);
        // Frame 2: clamped to (56,56); mid-frame pos change must not show
        run_frame(3000, 3, 40, st);
        chk("f2_white_count", st.n_white, 64);
        chk("f2_minx", st.minx, 56);
        chk("f2_maxx", st.maxx, 63);
        chk("f2_miny", st.miny, 56);
        chk("f2_maxy", st.maxy, 63);
        run_frame(-1, 0, 0, st);
        chk("f3_minx", st.minx, 3);
        chk("f3_miny", st.miny, 40);
`endif

        // Randomized clock-enable and position traffic
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            #1 ce = ($urandom_range(3) != 0);
            if ($urandom_range(299) == 0) begin
                pos_x = 10'($urandom_range(1023));
                pos_y = 10'($urandom_range(1023));
            end
        end
        @(negedge clk);
        #1 ce = 1'b1;

        // Mid-frame reset at pixel (30,30)
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (de && c_w == 10'd30 && c_h == 10'd30) begin
                found = 1'b1;
                break;
            end
        end
        chk("find_pixel_30_30", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_de", int'(de), 0);
        chk("midrst_red", int'(red), 0);
        chk("midrst_cw", int'(c_w), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fs", int'(frame_start), 1);
        chk("restart_de", int'(de), 1);
        chk("restart_cw", int'(c_w), 0);
        chk("restart_ch", int'(c_h), 0);
        repeat (99) @(negedge clk);
        chk("pre_hold_cw", int'(c_w), 99 % HT);
        chk("pre_hold_ch", int'(c_h), 99 / HT);
        #1 ce = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_cw", int'(c_w), 99 % HT);
        chk("hold_ch", int'(c_h), 99 / HT);
        chk("hold_de", int'(de), 1);
        #1 ce = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
